// File: rtl/reg_share_arbiter_if.sv
// Handshake bundle between the requesters and the shared-register arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface reg_share_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [2:0]       req;
  logic [1:0]       cmd0;
  logic [1:0]       cmd1;
  logic [1:0]       cmd2;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [2:0]       grant;
  logic             ack;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nq;

  modport master (
    output req, cmd0, cmd1, cmd2, data0, data1, data2,
    input  grant, ack, busy, q, nq
  );

  modport slave (
    input  req, cmd0, cmd1, cmd2, data0, data1, data2,
    output grant, ack, busy, q, nq
  );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter for three requesters sharing one register.
// Each grant performs exactly one write (load, set, reset or clear), then waits for the owner to release.
module reg_share_arbiter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] PAT_SET = 4'b0110,
  parameter logic [WIDTH-1:0] PAT_RST = 4'b0011
) (
  input logic                 clk,
  input logic                 reset,
  reg_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WRITE   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_SET   = 2'b01,
    CMD_RESET = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  state_t           state;
  logic [2:0]       grant;
  logic             ack;
  logic [WIDTH-1:0] q;
  logic [1:0]       last;
  logic [1:0]       owner;
  cmd_t             cap_cmd;
  logic [WIDTH-1:0] cap_data;

  logic [1:0]       win_idx;
  logic             win_valid;
  cmd_t             sel_cmd;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] wr_val;
  logic             owner_req;

  // Search starts one past the last owner, so a requester holding req is never skipped twice.
  always_comb begin
    win_valid = |bus.req;
    win_idx   = 2'd0;
    case (last)
      2'd0: begin
        if (bus.req[1])      win_idx = 2'd1;
        else if (bus.req[2]) win_idx = 2'd2;
        else                 win_idx = 2'd0;
      end
      2'd1: begin
        if (bus.req[2])      win_idx = 2'd2;
        else if (bus.req[0]) win_idx = 2'd0;
        else                 win_idx = 2'd1;
      end
      default: begin
        if (bus.req[0])      win_idx = 2'd0;
        else if (bus.req[1]) win_idx = 2'd1;
        else                 win_idx = 2'd2;
      end
    endcase
  end

  always_comb begin
    sel_cmd  = CMD_LOAD;
    sel_data = '0;
    case (win_idx)
      2'd0: begin
        sel_cmd  = cmd_t'(bus.cmd0);
        sel_data = bus.data0;
      end
      2'd1: begin
        sel_cmd  = cmd_t'(bus.cmd1);
        sel_data = bus.data1;
      end
      default: begin
        sel_cmd  = cmd_t'(bus.cmd2);
        sel_data = bus.data2;
      end
    endcase
  end

  always_comb begin
    wr_val = '0;
    case (cap_cmd)
      CMD_LOAD:  wr_val = cap_data;
      CMD_SET:   wr_val = PAT_SET;
      CMD_RESET: wr_val = PAT_RST;
      default:   wr_val = '0;
    endcase
  end

  assign owner_req = |(bus.req & grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      ack      <= 1'b0;
      q        <= '0;
      last     <= 2'd2;
      owner    <= 2'd0;
      cap_cmd  <= CMD_LOAD;
      cap_data <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant    <= 3'b001 << win_idx;
            owner    <= win_idx;
            cap_cmd  <= sel_cmd;
            cap_data <= sel_data;
            state    <= WRITE;
          end
        end
        WRITE: begin
          q     <= wr_val;
          ack   <= 1'b1;
          state <= RELEASE;
        end
        RELEASE: begin
          if (!owner_req) begin
            grant <= '0;
            last  <= owner;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant = grant;
  assign bus.ack   = ack;
  assign bus.busy  = (state != IDLE);
  assign bus.q     = q;
  assign bus.nq    = ~q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: stimulus queues expected writes, a monitor checks them on ack.
module tb_reg_share_arbiter;
  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  reg_share_arbiter #(
    .WIDTH  (WIDTH),
    .PAT_SET(4'b0110),
    .PAT_RST(4'b0011)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0] grant;
    logic [3:0] q;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest queued expectation.
  logic ack_prev = 1'b0;
  exp_t e;
  logic [3:0] nq_exp;
  logic [2:0] g;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      g = bus.grant;
      check("grant_onehot", 32'((g & (g - 3'd1)) == 3'd0), 32'd1);
      if (bus.ack === 1'b1) begin
        check("ack_single_pulse", 32'(ack_prev), 32'd0);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got ack with q=%0h expected no ack", bus.q);
        end else begin
          e = sb.pop_front();
          nq_exp = ~e.q;
          check({e.name, "_grant"}, 32'(bus.grant), 32'(e.grant));
          check({e.name, "_q"}, 32'(bus.q), 32'(e.q));
          check({e.name, "_nq"}, 32'(bus.nq), 32'(nq_exp));
        end
      end
      ack_prev = bus.ack;
    end else begin
      ack_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 3'b000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack !== 1'b1 && n < 20);
    checks++;
    if (bus.ack !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack_timeout: got no ack in %0d cycles expected ack", name, n);
    end
  endtask

  task automatic serve(input int idx, input logic [1:0] cmd, input logic [3:0] data,
                       input logic [2:0] exp_grant, input logic [3:0] exp_q, input string name);
    sb.push_back('{exp_grant, exp_q, name});
    case (idx)
      0: begin bus.cmd0 = cmd; bus.data0 = data; end
      1: begin bus.cmd1 = cmd; bus.data1 = data; end
      default: begin bus.cmd2 = cmd; bus.data2 = data; end
    endcase
    bus.req[idx] = 1'b1;
    wait_ack(name);
    bus.req[idx] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req = 3'b000;
    bus.cmd0 = 2'b00; bus.cmd1 = 2'b00; bus.cmd2 = 2'b00;
    bus.data0 = 4'h0; bus.data1 = 4'h0; bus.data2 = 4'h0;

    // Reset state, then single LOAD from requester 0 with latency checks
    do_reset();
    check("rst_q", 32'(bus.q), 32'h0);
    check("rst_nq", 32'(bus.nq), 32'hF);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_ack", 32'(bus.ack), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    sb.push_back('{3'b001, 4'b1010, "t1"});
    bus.cmd0 = 2'b00; bus.data0 = 4'b1010; bus.req = 3'b001;
    tick();
    check("t1_grant_latency", 32'(bus.grant), 32'h1);
    check("t1_busy", 32'(bus.busy), 32'h1);
    check("t1_ack_early", 32'(bus.ack), 32'h0);
    check("t1_q_hold", 32'(bus.q), 32'h0);
    tick();
    check("t1_ack", 32'(bus.ack), 32'h1);
    bus.req = 3'b000;
    tick();
    check("t1_idle_busy", 32'(bus.busy), 32'h0);
    check("t1_idle_grant", 32'(bus.grant), 32'h0);

    // Three simultaneous LOADs served in rotating order
    do_reset();
    sb.push_back('{3'b001, 4'b0001, "t2_r0"});
    sb.push_back('{3'b010, 4'b0010, "t2_r1"});
    sb.push_back('{3'b100, 4'b0100, "t2_r2"});
    bus.cmd0 = 2'b00; bus.cmd1 = 2'b00; bus.cmd2 = 2'b00;
    bus.data0 = 4'b0001; bus.data1 = 4'b0010; bus.data2 = 4'b0100;
    bus.req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      wait_ack("t2");
      bus.req[i] = 1'b0;
    end
    tick();
    tick();

    // SET, RESET, CLEAR commands
    do_reset();
    serve(1, 2'b01, 4'h0, 3'b010, 4'b0110, "t3_set");
    serve(2, 2'b10, 4'h0, 3'b100, 4'b0011, "t3_rst");
    serve(0, 2'b11, 4'h0, 3'b001, 4'b0000, "t3_clr");

    // Reset arriving during WRITE discards the pending LOAD
    do_reset();
    bus.cmd0 = 2'b00; bus.data0 = 4'b1111; bus.req = 3'b001;
    tick();
    check("t4_grant_before_rst", 32'(bus.grant), 32'h1);
    reset = 1'b1;
    bus.req = 3'b000;
    tick();
    reset = 1'b0;
    check("t4_q", 32'(bus.q), 32'h0);
    check("t4_nq", 32'(bus.nq), 32'hF);
    check("t4_grant", 32'(bus.grant), 32'h0);
    check("t4_ack", 32'(bus.ack), 32'h0);
    check("t4_busy", 32'(bus.busy), 32'h0);
    tick();
    tick();
    check("t4_q_after", 32'(bus.q), 32'h0);

    // Owner holds after ack while requester 2 waits
    do_reset();
    sb.push_back('{3'b001, 4'b0101, "t5_owner"});
    bus.cmd0 = 2'b00; bus.data0 = 4'b0101; bus.req = 3'b001;
    wait_ack("t5_owner");
    sb.push_back('{3'b100, 4'b0110, "t5_r2"});
    bus.cmd2 = 2'b01;
    bus.req = 3'b101;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_grant", 32'(bus.grant), 32'h1);
      check("t5_hold_ack", 32'(bus.ack), 32'h0);
      check("t5_hold_q", 32'(bus.q), 32'h5);
    end
    bus.req[0] = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.grant !== 3'b100 && n < 6);
    check("t5_handover_within_2", 32'(n <= 2 && bus.grant === 3'b100), 32'h1);
    wait_ack("t5_r2");
    bus.req = 3'b000;
    tick();
    tick();

    // Data changed during WRITE must not affect the captured LOAD
    do_reset();
    sb.push_back('{3'b001, 4'b1100, "t6"});
    bus.cmd0 = 2'b00; bus.data0 = 4'b1100; bus.req = 3'b001;
    tick();
    bus.data0 = 4'b0111;
    tick();
    bus.req = 3'b000;
    tick();
    tick();

    tick();
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, width of shared register and every data port.
REQ-002 Parameter PAT_SET, default 4'b0110, value loaded by the SET command.
REQ-003 Parameter PAT_RST, default 4'b0011, value loaded by the RESET command.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  3  per-requester request, bit i = requester i; level, held until grant.
REQ-007 cmd0, cmd1, cmd2  input  2 each  requester command: 00 LOAD, 01 SET, 10 RESET, 11 CLEAR.
REQ-008 data0, data1, data2  input  WIDTH each  requester write data, used only for LOAD.
REQ-009 grant  output  3  one-hot owner of the shared register, 000 when free.
REQ-010 ack  output  1  one-cycle pulse, write by current owner committed.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 q  output  WIDTH  shared register value.
REQ-013 nq  output  WIDTH  bitwise complement of q, always.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WRITE, RELEASE.
REQ-015 IDLE, req != 000: select winner round-robin, search from (last+1) mod 3 upward; next cycle grant = winner one-hot, state WRITE.
REQ-016 Winner's cmd and data SHALL be captured on that same edge; later input changes do not affect the write.
REQ-017 IDLE, req == 000: grant stays 000, state IDLE.
REQ-018 WRITE: on the next edge q SHALL update: LOAD -> captured data, SET -> PAT_SET, RESET -> PAT_RST, CLEAR -> all zeros; ack = 1 for that following cycle; state RELEASE.
REQ-019 Write in WRITE SHALL complete even if the owner deasserts req during WRITE.
REQ-020 RELEASE: while req[owner] = 1, hold grant and q; ack = 0.
REQ-021 RELEASE with req[owner] = 0: next edge grant = 000, last = owner index, state IDLE.
REQ-022 Latency: req sampled at edge N -> grant high after N, q updated and ack high after N+1; minimum 3-cycle IDLE-to-IDLE turnaround.
REQ-023 Requests from non-owners during WRITE/RELEASE SHALL be ignored but honoured in IDLE afterwards; no request is lost while held.
REQ-024 Simultaneous requests SHALL be served in rotating order; no requester is granted twice while another holds req continuously.
REQ-025 grant SHALL never have more than one bit set.
REQ-026 q and nq SHALL change only on the WRITE->RELEASE edge or on reset.

Reset
REQ-027 reset = 1 at an edge SHALL force, from any state, including mid-WRITE: state IDLE, q = 0000, nq = 1111, grant = 000, ack = 0, busy = 0, last = 2 (requester 0 first).
REQ-028 A write pending in WRITE when reset is sampled SHALL be discarded.
REQ-029 reset SHALL take priority over every request and command on the same edge.

Verification
REQ-030 Reset, then req = 001, cmd0 = LOAD, data0 = 1010 -> grant = 001 next cycle; q = 1010, nq = 0101, ack pulse one cycle later.
REQ-031 req = 111 held, all commands LOAD, data0/1/2 = 0001/0010/0100, each requester drops req after its ack -> grants in order 001, 010, 100; q sequence 0001, 0010, 0100.
REQ-032 Owner 1 cmd = SET, then owner 2 cmd = RESET, then owner 0 cmd = CLEAR -> q = 0110, then 0011, then 0000; nq always ~q.
REQ-033 Reset asserted in WRITE (owner 0 LOAD 1111) -> q stays 0000, no ack, grant = 000 next cycle.
REQ-034 Owner holds req five cycles after ack; requester 2 requests meanwhile -> grant stays on owner, ack single pulse; requester 2 granted within two cycles of owner release.
REQ-035 Owner changes data0 to 0111 during WRITE after capturing 1100 -> q = 1100.
